// File: rtl/irq_priority_ctrl.sv
// ---------------------------------------------------------------------------
// irq_priority_ctrl
//
// Eight-line interrupt controller with a fixed-priority selection
// (bit 7 = highest priority). Incoming requests are latched into a pending
// register and filtered by a software mask. One winner is presented to the
// core, which then takes it through a request / acknowledge / end-of-interrupt
// handshake. Only one source is in service at any time.
//
// Optional build macro:
//   IRQ_EDGE_EN  defined   -> pending bits are set on rising edges of irq_in
//                             (uses a one-cycle history register)
//                undefined -> pending bits are set while irq_in is high
//
// Parameters:
//   RESET_MASK   mask register value after reset (1 = line masked)
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   irq_in       raw interrupt lines, bit 7 highest priority
//   mask_we      mask register write strobe
//   mask_wdata   mask register write data
//   irq_ack      core accepts the presented interrupt (honoured in REQ only)
//   irq_eoi      core finished servicing (honoured in SERVICE only)
//   irq_req      an interrupt is being presented to the core
//   irq_id       index of the presented / in-service line
//   busy         a line is in service
//   pending      raw pending register contents (mask not applied)
// ---------------------------------------------------------------------------
module irq_priority_ctrl #(
    parameter logic [7:0] RESET_MASK = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic       irq_ack,
    input  logic       irq_eoi,
    output logic       irq_req,
    output logic [2:0] irq_id,
    output logic       busy,
    output logic [7:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] mask_q;
    logic [7:0] effective;
    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [2:0] irq_id_q;
    logic [2:0] irq_id_d;
    logic [2:0] winner;
    logic       ack_take;

    // Highest set index of v; returns 0 when v is empty (caller guards).
    function automatic logic [2:0] highest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // -----------------------------------------------------------------------
    // Request detection: level or rising edge
    // -----------------------------------------------------------------------
`ifdef IRQ_EDGE_EN
    logic [7:0] irq_in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_in_q <= 8'h00;
        end else begin
            irq_in_q <= irq_in;
        end
    end

    assign set_vec = irq_in & ~irq_in_q;
`else
    assign set_vec = irq_in;
`endif

    // -----------------------------------------------------------------------
    // Selection
    // -----------------------------------------------------------------------
    // Masked lines stay pending; they only drop out of the selection.
    assign effective = pending_q & ~mask_q;
    assign winner    = highest_index(effective);

    // Only an acknowledge of the presented request clears anything, and it
    // clears exactly the presented line.
    assign ack_take = (state_q == REQ) && irq_ack;
    assign clr_vec  = ack_take ? (8'b0000_0001 << irq_id_q) : 8'h00;

    // -----------------------------------------------------------------------
    // Pending register next value
    // -----------------------------------------------------------------------
    always_comb begin
`ifdef IRQ_EDGE_EN
        // A rising edge coinciding with the ack of the same line must not be
        // lost, so the set is applied after the clear.
        pending_d = (pending_q & ~clr_vec) | set_vec;
`else
        // A level source that is still high re-pends on the following cycle,
        // so the clear is applied last.
        pending_d = (pending_q | set_vec) & ~clr_vec;
`endif
    end

    // -----------------------------------------------------------------------
    // Handshake FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;

        unique case (state_q)
            IDLE: begin
                if (effective != 8'h00) begin
                    irq_id_d = winner;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // irq_id is frozen: no preemption, no re-evaluation on mask
                // changes. A simultaneous eoi is ignored here.
                if (irq_ack) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_id_q  <= 3'd0;
            pending_q <= 8'h00;
            mask_q    <= RESET_MASK;
        end else begin
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (straight decodes of registered state)
    // -----------------------------------------------------------------------
    assign irq_req = (state_q == REQ);
    assign busy    = (state_q == SERVICE);
    assign irq_id  = irq_id_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_priority_ctrl
//
// Directed scenarios followed by a randomized phase, all checked every cycle
// against a behavioural model of the controller kept in the bench. Inputs
// change just after the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_irq_priority_ctrl;

    localparam logic [7:0] RESET_MASK = 8'h00;
`ifdef IRQ_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       irq_ack;
    logic       irq_eoi;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       busy;
    logic [7:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_hist;
    logic       m_req;
    logic       m_busy;
    logic [2:0] m_id;

    irq_priority_ctrl #(.RESET_MASK(RESET_MASK)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .busy       (busy),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One clock of the model, using the inputs present at the rising edge.
    task automatic model_step();
        logic [7:0] eff;
        logic [7:0] setv;
        logic [7:0] clrv;
        int         top;
        if (rst) begin
            m_pend = 8'h00;
            m_mask = RESET_MASK;
            m_hist = 8'h00;
            m_req  = 1'b0;
            m_busy = 1'b0;
            m_id   = 3'd0;
        end else begin
            eff  = m_pend & ~m_mask;
            setv = EDGE_MODE ? (irq_in & ~m_hist) : irq_in;
            clrv = 8'h00;
            if (m_req && irq_ack) clrv[m_id] = 1'b1;
            if (EDGE_MODE) m_pend = (m_pend & ~clrv) | setv;
            else           m_pend = (m_pend | setv) & ~clrv;

            if (!m_req && !m_busy) begin
                if (eff != 8'h00) begin
                    top = 7;
                    while (!eff[top]) top--;
                    m_id  = 3'(top);
                    m_req = 1'b1;
                end
            end else if (m_req) begin
                if (irq_ack) begin
                    m_req  = 1'b0;
                    m_busy = 1'b1;
                end
            end else if (irq_eoi) begin
                m_busy = 1'b0;
            end

            if (mask_we) m_mask = mask_wdata;
            m_hist = irq_in;
        end
    endtask

    task automatic compare_all();
        check("irq_req", {7'd0, irq_req}, {7'd0, m_req});
        check("busy",    {7'd0, busy},    {7'd0, m_busy});
        check("irq_id",  {5'd0, irq_id},  {5'd0, m_id});
        check("pending", pending,         m_pend);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic clear_inputs();
        irq_in     = 8'h00;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        irq_ack    = 1'b0;
        irq_eoi    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int rises;
    logic prev_req;

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_req",     {7'd0, irq_req}, 8'h00);
        check("rst_busy",    {7'd0, busy},    8'h00);
        check("rst_id",      {5'd0, irq_id},  8'h00);
        check("rst_pending", pending,         8'h00);

        // Scenario: two lines, highest wins, ack clears only the winner
        irq_in = 8'h24;
        tick();
        check("sel_no_req_yet", {7'd0, irq_req}, 8'h00);
        check("sel_pending",    pending,         8'h24);
        tick();
        check("sel_req",        {7'd0, irq_req}, 8'h01);
        check("sel_id5",        {5'd0, irq_id},  8'h05);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_busy",       {7'd0, busy},    8'h01);
        check("ack_req_low",    {7'd0, irq_req}, 8'h00);
`ifndef IRQ_EDGE_EN
        check("ack_clear_wins", pending,         8'h04);
        tick();
        check("level_repend",   pending,         8'h24);
`endif
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        check("eoi_idle_busy",  {7'd0, busy},    8'h00);
        check("eoi_idle_req",   {7'd0, irq_req}, 8'h00);
        tick();

        // Scenario: masked line retained, lower line served, unmask later
        do_reset();
        mask_we    = 1'b1;
        mask_wdata = 8'h80;
        irq_in     = 8'h81;
        tick();
        mask_we = 1'b0;
        tick();
        check("mask_id0",       {5'd0, irq_id},  8'h00);
        check("mask_p7_kept",   {7'd0, pending[7]}, 8'h01);
        irq_ack    = 1'b1;
        mask_we    = 1'b1;
        mask_wdata = 8'h00;
        irq_in     = 8'h00;
        tick();
        clear_inputs();
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        tick();
        check("unmask_id7",     {5'd0, irq_id},  8'h07);
        check("unmask_req",     {7'd0, irq_req}, 8'h01);

        // Scenario: no preemption while presenting
        do_reset();
        irq_in = 8'h04;
        tick();
        tick();
        check("nopre_id2",      {5'd0, irq_id},  8'h02);
        irq_in = 8'h44;
        tick();
        check("nopre_hold",     {5'd0, irq_id},  8'h02);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("nopre_svc_id",   {5'd0, irq_id},  8'h02);
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        tick();
        check("nopre_next_id6", {5'd0, irq_id},  8'h06);

        // Scenario: stray ack in IDLE and stray eoi in REQ are ignored
        do_reset();
        irq_in  = 8'h08;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("stray_ack_pend", pending,         8'h08);
        tick();
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
        check("stray_eoi_req",  {7'd0, irq_req}, 8'h01);
        check("stray_eoi_busy", {7'd0, busy},    8'h00);
        irq_ack = 1'b1;
        irq_eoi = 1'b1;
        tick();
        clear_inputs();
        check("ack_eoi_same",   {7'd0, busy},    8'h01);

        // Scenario: reset while in service with lines pending
        do_reset();
        irq_in = 8'hF0;
        tick();
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        if (!EDGE_MODE) tick();
        check("svc_busy",       {7'd0, busy},    8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        irq_in = 8'h00;
        check("rst_svc_req",    {7'd0, irq_req}, 8'h00);
        check("rst_svc_busy",   {7'd0, busy},    8'h00);
        check("rst_svc_id",     {5'd0, irq_id},  8'h00);
        check("rst_svc_pend",   pending,         8'h00);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        check("rst_mask_req",   {7'd0, irq_req}, {7'd0, ~RESET_MASK[0]});

`ifdef IRQ_EDGE_EN
        // Edge mode: held line yields one request; edge coinciding with ack
        do_reset();
        rises    = 0;
        prev_req = irq_req;
        irq_in   = 8'h08;
        for (int i = 0; i < 20; i++) begin
            irq_ack = irq_req;
            irq_eoi = busy;
            tick();
            if (irq_req && !prev_req) rises++;
            prev_req = irq_req;
        end
        clear_inputs();
        check("edge_one_req", 8'(rises), 8'h01);
        do_reset();
        irq_in = 8'h08;
        tick();
        tick();
        irq_in = 8'h00;
        tick();
        irq_in  = 8'h08;
        irq_ack = 1'b1;
        tick();
        clear_inputs();
        check("edge_set_wins", {7'd0, pending[3]}, 8'h01);
`endif

        // Randomized phase
        do_reset();
        for (int i = 0; i < 800; i++) begin
            irq_in     = 8'($urandom & $urandom);
            mask_we    = ($urandom_range(0, 9) == 0);
            mask_wdata = 8'($urandom);
            irq_ack    = ($urandom_range(0, 2) == 0);
            irq_eoi    = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 149) == 0);
            tick();
        end
        clear_inputs();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
